z80_bus_cycle_fsm: RTL and testbench
====================================

Name: z80_bus_cycle_fsm

Overview:
Parametrised machine-cycle sequencer that generalises the opcode-fetch FSM to all Z80 external bus cycles: opcode fetch (OCF), memory read (MR), memory write (MW), port read (PR) and port write (PW).
Steps T1/T2/TW/T3(/T4) and drives MREQ_L/IORQ_L/RD_L/WR_L/M1_L/RFSH_L and the address/data buses. Supports configurable forced wait states, external WAIT_L stretching and a refresh counter.
Sits between control_fsm, which issues one cycle request at a time, and the top-level pins.

Parameters:
ADDR_W, 16, address bus width.
RFSH_W, 7, refresh counter width; ADDR_W must be at least RFSH_W.
OCF_WAIT, 0, forced wait states inserted in OCF cycles (0-7).
MEM_WAIT, 0, forced wait states inserted in MR/MW cycles (0-7).
IO_WAIT, 1, forced wait states inserted in PR/PW cycles (0-7).

Ports:
clk  in  1  clock; all state changes on the rising edge
rst_L  in  1  asynchronous active-low reset
cyc_start  in  1  request strobe; accepted when the block is idle or in the done cycle
cyc_type  in  3  0=OCF, 1=MR, 2=MW, 3=PR, 4=PW; 5-7 reserved
cyc_addr  in  ADDR_W  cycle address, captured at accept
cyc_wdata  in  8  write data, captured at accept
cyc_done  out  1  one-cycle pulse in the final T-state
cyc_rdata  out  8  read data; holds until the next read cycle
busy  out  1  high from T1 through the final T-state
data_in  in  8  data bus input
data_out  out  8  data bus output
data_oe  out  1  data bus output enable
addr_out  out  ADDR_W  address bus
WAIT_L  in  1  external wait request, active low
M1_L, MREQ_L, IORQ_L, RD_L, WR_L, RFSH_L  out  1 each  bus strobes, active low

Behaviour:
- Reset (asynchronous, any state, including mid-cycle):
  - state = IDLE.
  - All strobes = 1; busy, cyc_done and data_oe = 0.
  - addr_out, data_out, cyc_rdata and the refresh counter = 0.
- States: IDLE, T1, T2, TW, T3, T4. All outputs are decoded from registered state and the captured request; no combinational path from inputs to strobes.
- Request accept:
  - Condition: cyc_start=1, a valid type, and state IDLE or the done cycle.
  - Captures type, addr and wdata; next state T1.
  - Reserved type: ignored, no cycle, no done.
  - cyc_start while busy and not in the done cycle: ignored.
  - An accept in the done cycle gives back-to-back T1 with no IDLE gap.
- Wait counter:
  - Loaded at T1 with the forced wait count for the type.
  - Exit of T2 or TW: counter > 0 → TW and decrement; else WAIT_L=0 → TW; else T3.
  - WAIT_L is sampled only at those edges.
- Read data capture: cyc_rdata <= data_in on the edge leaving T2/TW into T3, for OCF, MR and PR only.
- OCF:
  - T1-T2-TW: M1_L=0, MREQ_L=0, RD_L=0, addr_out = captured addr.
  - T3: M1_L=1, RD_L=1, MREQ_L=0, RFSH_L=0, addr_out = zero-extended refresh counter.
  - T4: MREQ_L=1, RFSH_L=0, same address, cyc_done=1.
  - Refresh counter increments on exit of T4 and wraps at 2^RFSH_W.
  - Minimum latency: accept edge to done = 4 cycles.
- MR: T1-T3 MREQ_L=0 and RD_L=0; done in T3; minimum 3 cycles.
- MW:
  - T1-T3 MREQ_L=0 and data_oe=1, data_out = wdata.
  - WR_L=0 in T2, TW and T3; WR_L=1 in T1.
  - Done in T3.
- PR/PW: as MR/MW with IORQ_L in place of MREQ_L. IORQ_L=1 in T1, 0 from T2 through T3.
- After done with no new accept: IDLE, all strobes high, data_oe=0, addr_out holds its last value.
- M1_L and RFSH_L are never low in non-OCF cycles. MREQ_L and IORQ_L are never low in the same cycle.

Test Plan:
1. Reset mid-OCF T2 → all strobes 1, busy=0, refresh=0 immediately, without waiting for a clock edge; next OCF starts with refresh address 0.
2. OCF at addr 0x1234, data_in=0x3E, WAIT_L=1, OCF_WAIT=0 → addr 0x1234 in T1-T2, cyc_rdata=0x3E, T3/T4 addr=0x0000 with RFSH_L=0; done at cycle 4; next OCF refresh address 0x0001.
3. 128 back-to-back OCFs (RFSH_W=7) → refresh address walks 0x00..0x7F and wraps to 0x00; no IDLE cycles between fetches.
4. MW addr 0x8000, wdata 0xA5, WAIT_L low for 2 samples, MEM_WAIT=0 → two TW states; WR_L low from T2 to T3; data_oe high T1-T3; done at cycle 5.
5. PR port 0x00FE, IO_WAIT=1, WAIT_L=1 → exactly one TW; IORQ_L low T2-T3; cyc_rdata captured; done at cycle 4.
6. cyc_type=6 in IDLE, and cyc_start during an MR T2 → no bus activity and no done; in-progress MR completes unchanged.

Source files
------------

// File: rtl/z80_bus_cycle_fsm.sv
// Z80 machine-cycle sequencer: OCF/MR/MW/PR/PW bus cycles with forced and
// external waits, refresh addressing. Ports: request (cyc_*), bus pins, strobes.
module z80_bus_cycle_fsm #(
  parameter int ADDR_W   = 16,
  parameter int RFSH_W   = 7,
  parameter int OCF_WAIT = 0,
  parameter int MEM_WAIT = 0,
  parameter int IO_WAIT  = 1
) (
  input  logic              clk,
  input  logic              rst_L,
  input  logic              cyc_start,
  input  logic [2:0]        cyc_type,
  input  logic [ADDR_W-1:0] cyc_addr,
  input  logic [7:0]        cyc_wdata,
  output logic              cyc_done,
  output logic [7:0]        cyc_rdata,
  output logic              busy,
  input  logic [7:0]        data_in,
  output logic [7:0]        data_out,
  output logic              data_oe,
  output logic [ADDR_W-1:0] addr_out,
  input  logic              WAIT_L,
  output logic              M1_L,
  output logic              MREQ_L,
  output logic              IORQ_L,
  output logic              RD_L,
  output logic              WR_L,
  output logic              RFSH_L
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_T1,
    S_T2,
    S_TW,
    S_T3,
    S_T4
  } state_t;

  typedef enum logic [2:0] {
    C_OCF = 3'd0,
    C_MR  = 3'd1,
    C_MW  = 3'd2,
    C_PR  = 3'd3,
    C_PW  = 3'd4
  } cyc_t;

  state_t            state_q;
  state_t            state_d;
  cyc_t              typ_q;
  logic [2:0]        wcnt_q;
  logic [2:0]        wcnt_d;
  logic [RFSH_W-1:0] rfsh_q;
  logic [ADDR_W-1:0] addr_q;
  logic [7:0]        wdata_q;
  logic [7:0]        rdata_q;

  logic is_ocf;
  logic is_io;
  logic is_rd;
  logic is_wr;
  logic type_ok;
  logic done_cyc;
  logic accept;
  logic enter_t3;
  logic [2:0] load_wait;

  // phase flags
  logic ph_t1;
  logic ph_t2w;
  logic ph_t3;
  logic ph_t4;

  always_comb begin
    is_ocf = 1'b0;
    is_io  = 1'b0;
    is_rd  = 1'b0;
    is_wr  = 1'b0;
    unique case (1'b1)
      (typ_q == C_OCF): begin
        is_ocf = 1'b1;
        is_rd  = 1'b1;
      end
      (typ_q == C_MR): is_rd = 1'b1;
      (typ_q == C_MW): is_wr = 1'b1;
      (typ_q == C_PR): begin
        is_io = 1'b1;
        is_rd = 1'b1;
      end
      (typ_q == C_PW): begin
        is_io = 1'b1;
        is_wr = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    ph_t1  = 1'b0;
    ph_t2w = 1'b0;
    ph_t3  = 1'b0;
    ph_t4  = 1'b0;
    unique case (state_q)
      S_T1:       ph_t1  = 1'b1;
      S_T2, S_TW: ph_t2w = 1'b1;
      S_T3:       ph_t3  = 1'b1;
      S_T4:       ph_t4  = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    load_wait = 3'd0;
    unique case (1'b1)
      (cyc_type == 3'd0):
        load_wait = 3'(OCF_WAIT);
      (cyc_type == 3'd1),
      (cyc_type == 3'd2):
        load_wait = 3'(MEM_WAIT);
      (cyc_type == 3'd3),
      (cyc_type == 3'd4):
        load_wait = 3'(IO_WAIT);
      default: ;
    endcase
  end

  // OCF finishes in T4, every other cycle in T3
  assign done_cyc = ph_t4 | (ph_t3 & ~is_ocf);
  assign type_ok  = (cyc_type <= 3'd4);
  assign accept   = cyc_start & type_ok &
                    ((state_q == S_IDLE) | done_cyc);

  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (accept) state_d = S_T1;
      end
      S_T1: state_d = S_T2;
      S_T2, S_TW: begin
        if (wcnt_q != 3'd0) begin
          state_d = S_TW;
          wcnt_d  = wcnt_q - 3'd1;
        end else if (!WAIT_L) begin
          state_d = S_TW;
        end else begin
          state_d = S_T3;
        end
      end
      S_T3: begin
        if (is_ocf)      state_d = S_T4;
        else if (accept) state_d = S_T1;
        else             state_d = S_IDLE;
      end
      S_T4: begin
        if (accept) state_d = S_T1;
        else        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (accept) wcnt_d = load_wait;
  end

  assign enter_t3 = ph_t2w & (state_d == S_T3);

  always_ff @(posedge clk or negedge rst_L) begin
    if (!rst_L) begin
      state_q <= S_IDLE;
      typ_q   <= C_OCF;
      wcnt_q  <= 3'd0;
      rfsh_q  <= '0;
      addr_q  <= '0;
      wdata_q <= 8'h00;
      rdata_q <= 8'h00;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
      if (accept) begin
        typ_q   <= cyc_t'(cyc_type);
        addr_q  <= cyc_addr;
        wdata_q <= cyc_wdata;
      end
      if (enter_t3 && is_rd)
        rdata_q <= data_in;
      // refresh address replaces the fetch address for T3/T4
      if (enter_t3 && is_ocf)
        addr_q <= ADDR_W'(rfsh_q);
      if (ph_t4)
        rfsh_q <= rfsh_q + 1'b1;
    end
  end

  assign addr_out  = addr_q;
  assign data_out  = wdata_q;
  assign cyc_rdata = rdata_q;
  assign cyc_done  = done_cyc;
  assign busy      = (state_q != S_IDLE);

  always_comb begin
    M1_L    = ~(is_ocf & (ph_t1 | ph_t2w));
    RFSH_L  = ~(is_ocf & (ph_t3 | ph_t4));
    MREQ_L  = ~(~is_io & (ph_t1 | ph_t2w | ph_t3));
    IORQ_L  = ~(is_io & (ph_t2w | ph_t3));
    RD_L    = ~(is_rd & (ph_t1 | ph_t2w |
                         (ph_t3 & ~is_ocf)));
    WR_L    = ~(is_wr & (ph_t2w | ph_t3));
    data_oe = is_wr & (ph_t1 | ph_t2w | ph_t3);
  end

endmodule

// File: tb/tb_z80_bus_cycle_fsm.sv
// Bench for z80_bus_cycle_fsm: vector table + scoreboard, plus reset,
// back-to-back refresh walk and ignored-request sequences.
module tb_z80_bus_cycle_fsm;

  logic        clk = 1'b0;
  logic        rst_L;
  logic        cyc_start;
  logic [2:0]  cyc_type;
  logic [15:0] cyc_addr;
  logic [7:0]  cyc_wdata;
  logic        cyc_done;
  logic [7:0]  cyc_rdata;
  logic        busy;
  logic [7:0]  data_in;
  logic [7:0]  data_out;
  logic        data_oe;
  logic [15:0] addr_out;
  logic        WAIT_L;
  logic        M1_L, MREQ_L, IORQ_L;
  logic        RD_L, WR_L, RFSH_L;

  z80_bus_cycle_fsm dut (
    .clk(clk), .rst_L(rst_L),
    .cyc_start(cyc_start), .cyc_type(cyc_type),
    .cyc_addr(cyc_addr), .cyc_wdata(cyc_wdata),
    .cyc_done(cyc_done), .cyc_rdata(cyc_rdata),
    .busy(busy), .data_in(data_in),
    .data_out(data_out), .data_oe(data_oe),
    .addr_out(addr_out), .WAIT_L(WAIT_L),
    .M1_L(M1_L), .MREQ_L(MREQ_L), .IORQ_L(IORQ_L),
    .RD_L(RD_L), .WR_L(WR_L), .RFSH_L(RFSH_L)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [2:0]  typ;
    logic [15:0] addr;
    logic [7:0]  wd;
    logic [7:0]  din;
    logic [7:0]  wmask;
    int          lat;
    logic [7:0]  rdat;
    int          rfa;
  } vec_t;

  typedef struct {
    int         lat;
    logic [7:0] rdat;
  } exp_t;

  vec_t tbl[7];
  exp_t sb[$];

  task automatic chk(string nm, logic [31:0] got,
                     logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
    end
  endtask

  task automatic idle_chk(string nm);
    chk({nm, "_strobes"},
        {M1_L, MREQ_L, IORQ_L, RD_L, WR_L, RFSH_L},
        6'h3F);
    chk({nm, "_busy"}, busy, 0);
    chk({nm, "_done"}, cyc_done, 0);
    chk({nm, "_oe"}, data_oe, 0);
  endtask

  task automatic run_vec(vec_t v);
    int   n;
    bit   got;
    exp_t e;
    bit   wr;
    bit   io;
    wr = (v.typ == 3'd2) || (v.typ == 3'd4);
    io = (v.typ == 3'd3) || (v.typ == 3'd4);
    cyc_type  = v.typ;
    cyc_addr  = v.addr;
    cyc_wdata = v.wd;
    data_in   = v.din;
    WAIT_L    = 1'b1;
    cyc_start = 1'b1;
    e.lat  = v.lat;
    e.rdat = v.rdat;
    sb.push_back(e);
    @(posedge clk); #1;
    cyc_start = 1'b0;
    n = 1;
    got = 1'b0;
    while (!got && n <= 20) begin
      WAIT_L = (n < 8) ? ~v.wmask[n] : 1'b1;
      @(negedge clk);
      chk("mreq_iorq_excl", !MREQ_L && !IORQ_L, 0);
      chk("busy_in_cycle", busy, 1);
      if (n == 1) chk("addr_t1", addr_out, v.addr);
      if (v.typ != 3'd0) begin
        chk("m1_rfsh_hi", {M1_L, RFSH_L}, 2'b11);
      end else begin
        chk("ocf_m1_rfsh", M1_L ^ RFSH_L, 1);
        if (!RFSH_L) chk("rfsh_addr", addr_out, v.rfa);
      end
      if (wr) begin
        chk("wr_l", WR_L, n == 1);
        chk("wr_oe", data_oe, 1);
        chk("wr_data", data_out, v.wd);
      end else begin
        chk("rd_wr_hi", WR_L, 1);
      end
      if (io) begin
        chk("iorq_l", IORQ_L, n == 1);
        chk("io_mreq_hi", MREQ_L, 1);
      end
      if (cyc_done) got = 1'b1;
      else begin
        @(posedge clk); #1;
        n++;
      end
    end
    e = sb.pop_front();
    if (!got) begin
      checks++;
      failures++;
      $display("FAIL done_timeout got=none exp=%0d", e.lat);
    end else begin
      chk("latency", n, e.lat);
      chk("rdata", cyc_rdata, e.rdat);
    end
    WAIT_L = 1'b1;
    @(posedge clk); #1;
    idle_chk("after_done");
    chk("addr_hold", addr_out,
        (v.typ == 3'd0) ? 16'(v.rfa) : v.addr);
  endtask

  initial begin
    tbl[0] = '{3'd0, 16'h1234, 8'h00, 8'h3E, 8'h00, 4, 8'h3E, 0};
    tbl[1] = '{3'd1, 16'h4000, 8'h00, 8'h5A, 8'h00, 3, 8'h5A, 0};
    tbl[2] = '{3'd2, 16'h8000, 8'hA5, 8'h00, 8'h0C, 5, 8'h5A, 0};
    tbl[3] = '{3'd3, 16'h00FE, 8'h00, 8'hC3, 8'h00, 4, 8'hC3, 0};
    tbl[4] = '{3'd4, 16'h0010, 8'h77, 8'h00, 8'h08, 5, 8'hC3, 0};
    tbl[5] = '{3'd1, 16'h0ABC, 8'h00, 8'h11, 8'h04, 4, 8'h11, 0};
    tbl[6] = '{3'd0, 16'h0100, 8'h00, 8'h6B, 8'h04, 5, 8'h6B, 1};

    rst_L     = 1'b0;
    cyc_start = 1'b0;
    cyc_type  = 3'd0;
    cyc_addr  = 16'h0;
    cyc_wdata = 8'h0;
    data_in   = 8'h0;
    WAIT_L    = 1'b1;
    #12;
    idle_chk("reset");
    chk("reset_addr", addr_out, 0);
    chk("reset_rdata", cyc_rdata, 0);
    chk("reset_dout", data_out, 0);
    @(negedge clk);
    rst_L = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 7; i++) run_vec(tbl[i]);

    // asynchronous reset in the middle of an OCF T2
    cyc_type  = 3'd0;
    cyc_addr  = 16'h5555;
    cyc_start = 1'b1;
    @(posedge clk); #1;
    cyc_start = 1'b0;
    @(posedge clk); #1;
    chk("pre_rst_m1", M1_L, 0);
    #1 rst_L = 1'b0;
    #1;
    idle_chk("mid_reset");
    chk("mid_reset_addr", addr_out, 0);
    chk("mid_reset_rdata", cyc_rdata, 0);
    @(negedge clk);
    rst_L = 1'b1;
    @(posedge clk); #1;

    // back-to-back OCFs, refresh walks and wraps
    cyc_type  = 3'd0;
    cyc_addr  = 16'h2000;
    data_in   = 8'h00;
    cyc_start = 1'b1;
    @(posedge clk); #1;
    for (int k = 0; k <= 128; k++) begin
      for (int c = 1; c <= 4; c++) begin
        @(negedge clk);
        chk("b2b_busy", busy, 1);
        chk("b2b_done", cyc_done, c == 4);
        if (c == 1) begin
          chk("b2b_addr", addr_out, 16'h2000);
          chk("b2b_m1", M1_L, 0);
        end
        if (c == 3) begin
          chk("b2b_rfsh_l", RFSH_L, 0);
          chk("b2b_rfsh_addr", addr_out, k & 8'h7F);
        end
        if (c == 4 && k == 128) cyc_start = 1'b0;
        @(posedge clk); #1;
      end
    end
    idle_chk("b2b_end");

    // reserved type in IDLE: no activity
    cyc_type  = 3'd6;
    cyc_start = 1'b1;
    repeat (3) begin
      @(negedge clk);
      idle_chk("reserved");
      @(posedge clk); #1;
    end
    cyc_start = 1'b0;

    // request during MR T2 is ignored
    cyc_type  = 3'd1;
    cyc_addr  = 16'h3333;
    data_in   = 8'h44;
    cyc_start = 1'b1;
    @(posedge clk); #1;
    cyc_start = 1'b0;
    @(posedge clk); #1;
    cyc_type  = 3'd2;
    cyc_addr  = 16'hFFFF;
    cyc_wdata = 8'h99;
    cyc_start = 1'b1;
    @(negedge clk);
    chk("mr_t2_rd", RD_L, 0);
    chk("mr_t2_done", cyc_done, 0);
    cyc_start = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    chk("mr_t3_done", cyc_done, 1);
    chk("mr_t3_addr", addr_out, 16'h3333);
    chk("mr_t3_wr", WR_L, 1);
    chk("mr_t3_oe", data_oe, 0);
    chk("mr_t3_rdata", cyc_rdata, 8'h44);
    @(posedge clk); #1;
    idle_chk("mr_end");
    chk("mr_end_addr", addr_out, 16'h3333);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
